mem_scanner: RTL
================

MEM_SCANNER -- requirements
Module: mem_scanner

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, memory word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter TICK_DIV, default 50000000, CLOCK_50 cycles per scan tick (>=2).
REQ-004 CLOCK_50  input  1  sole clock, all state updates on its rising edge.
REQ-005 aclr  input  1  reset, synchronous, active-low.
REQ-006 wr_en  input  1  write strobe, write performed on the rising edge while high.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  DATA_W  write data.
REQ-009 mode  input  2  scan mode: 00 HOLD, 01 UP, 10 DOWN, 11 STEP.
REQ-010 step  input  1  single-step request, used in STEP mode only, level input with internal edge detection.
REQ-011 lo_addr, hi_addr  input  ADDR_W each  inclusive scan window bounds.
REQ-012 rd_addr  output  ADDR_W  current scan address.
REQ-013 rd_data  output  DATA_W  registered memory word at rd_addr.
REQ-014 rd_valid  output  1  one-cycle pulse when rd_data reflects a newly advanced rd_addr.
REQ-015 tick  output  1  one-cycle pulse every TICK_DIV cycles.

Function
REQ-016 The prescaler SHALL count 0..TICK_DIV-1 continuously and assert tick for one cycle when the count equals TICK_DIV-1, then wrap to 0.
REQ-017 An advance event SHALL be: tick in UP/DOWN; rising edge of step (step high, previous sample low) in STEP; none in HOLD.
REQ-018 UP advance SHALL set rd_addr to rd_addr+1, or to lo_addr when rd_addr >= hi_addr.
REQ-019 DOWN advance SHALL set rd_addr to rd_addr-1, or to hi_addr when rd_addr <= lo_addr.
REQ-020 STEP advance SHALL follow the UP rule.
REQ-021 If rd_addr lies outside [lo_addr, hi_addr] when an advance occurs, the block SHALL load lo_addr (UP/STEP) or hi_addr (DOWN).
REQ-022 If lo_addr > hi_addr, the block SHALL treat the window as a single address lo_addr, and every advance SHALL load lo_addr.
REQ-023 The memory SHALL be a DATA_W x 2**ADDR_W array with one synchronous write port and one synchronous read port.
REQ-024 rd_data SHALL be registered from the memory at rd_addr every cycle, giving one cycle of latency after any rd_addr change.
REQ-025 rd_valid SHALL pulse exactly one cycle after each advance edge, together with the updated rd_data.
REQ-026 Simultaneous write and read to the same address SHALL return the old word (read-before-write), and the new word SHALL appear on the following cycle.
REQ-027 Memory contents SHALL be unaffected by reset and undefined until written.
REQ-028 A mode change SHALL take effect on the next cycle. The prescaler SHALL NOT be reset by a mode change.

Reset
REQ-029 While aclr is low at a rising edge: prescaler = 0, rd_addr = lo_addr, rd_data = 0, rd_valid = 0, tick = 0, step edge history = 1 (a held step generates no advance after reset).
REQ-030 Reset SHALL take priority over advance events and writes in the same cycle, and a write coincident with reset SHALL be discarded.

Structure
REQ-031 The mode encodings (HOLD/UP/DOWN/STEP) SHALL be defined as constants in the shared package mem_scan_pkg.
REQ-032 The prescaler SHALL be a separate parametrised sub-module, tick_gen (parameter DIV, outputs tick), instantiated once.
REQ-033 The memory SHALL be inferred inline, and no vendor megafunction SHALL be used.

Verification (bench: DATA_W=4, ADDR_W=5, TICK_DIV=4)
REQ-034 Reset then UP mode, window 0..31, with mem[0..3] written 5,6,7,8 -> rd_addr 1,2,3 on every 4th cycle, with rd_data 6,7,8 and rd_valid one cycle later.
REQ-035 UP mode, window 3..5, rd_addr=5 at tick -> rd_addr wraps to 3; DOWN mode at rd_addr=3 -> 5.
REQ-036 STEP mode, step held high for 10 cycles -> exactly one advance; HOLD mode for 20 cycles -> rd_addr constant and no rd_valid.
REQ-037 Write mem[7]=A while rd_addr=7 -> rd_data shows the old value that cycle and A the next cycle.
REQ-038 Reset asserted mid-scan at rd_addr=9 with lo_addr=2 -> rd_addr=2, rd_data=0, prescaler restarted (first tick 4 cycles after release).
REQ-039 lo_addr=6, hi_addr=4, UP mode -> rd_addr stays 6 across ticks, with rd_valid pulsing each tick.

Source files
------------

// File: rtl/mem_scan_pkg.sv
// rtl/mem_scan_pkg.sv - shared scan mode encodings for mem_scanner
package mem_scan_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler, one-cycle tick every DIV cycles
module tick_gen #(
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic aclr,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!aclr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Decoded from the count so reset (count = 0) forces tick low immediately.
  assign tick = (count == LAST);

endmodule

// File: rtl/mem_scanner.sv
// rtl/mem_scanner.sv - windowed memory scanner with tick/step driven address advance
module mem_scanner
  import mem_scan_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 50000000
) (
  input  logic              CLOCK_50,
  input  logic              aclr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic [ADDR_W-1:0] lo_addr,
  input  logic [ADDR_W-1:0] hi_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              tick
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              step_prev;
  logic              adv_pend;
  logic              advance;
  logic [ADDR_W-1:0] next_addr;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (CLOCK_50),
    .aclr (aclr),
    .tick (tick)
  );

  always_comb begin
    advance = 1'b0;
    case (mode)
      MODE_UP, MODE_DOWN: advance = tick;
      MODE_STEP:          advance = step & ~step_prev;
      default:            advance = 1'b0;
    endcase
  end

  // An inverted window collapses to lo_addr; an out-of-window address re-enters at the start edge.
  always_comb begin
    next_addr = rd_addr;
    if (lo_addr > hi_addr) begin
      next_addr = lo_addr;
    end else if (mode == MODE_DOWN) begin
      if (rd_addr <= lo_addr || rd_addr > hi_addr) next_addr = hi_addr;
      else                                         next_addr = rd_addr - 1'b1;
    end else begin
      if (rd_addr >= hi_addr || rd_addr < lo_addr) next_addr = lo_addr;
      else                                         next_addr = rd_addr + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (aclr && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // step_prev resets high so a step held through reset is not seen as a new edge.
  always_ff @(posedge CLOCK_50) begin
    if (!aclr) begin
      rd_addr   <= lo_addr;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      adv_pend  <= 1'b0;
      step_prev <= 1'b1;
    end else begin
      step_prev <= step;
      adv_pend  <= advance;
      rd_valid  <= adv_pend;
      rd_data   <= mem[rd_addr];
      if (advance) begin
        rd_addr <= next_addr;
      end
    end
  end

endmodule
